// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit hex display: steps one nibble per refresh slot
// and swaps in a newly loaded value only on frame boundaries.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    input  logic [7:0]  digit_en,
    output logic [3:0]  nibble,
    output logic [2:0]  sel,
    output logic        blank,
    output logic        frame_start
);

    localparam int DIGITS = 8;
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [2:0] SEL_LAST = 3'(DIGITS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    sel_q, sel_d;
    logic [31:0]   active_q, active_d;
    logic [31:0]   pending_q, pending_d;
    logic          pend_valid_q, pend_valid_d;
    logic          load_ready_q, load_ready_d;
    logic [3:0]    nibble_q, nibble_d;
    logic          frame_start_q, frame_start_d;
    logic          tick_s, boundary_s, commit_s, xfer_s;

    // Next-state: prescaler/sel stepping, handshake capture and frame-aligned commit.
    always_comb begin
        tick_s     = (presc_q == PRESC_LAST);
        boundary_s = tick_s && (sel_q == SEL_LAST);
        commit_s   = boundary_s && pend_valid_q;
        xfer_s     = load_valid && load_ready_q;

        presc_d = tick_s ? {PW{1'b0}} : presc_q + {{(PW-1){1'b0}}, 1'b1};
        sel_d   = tick_s ? sel_q + 3'd1 : sel_q;

        active_d  = commit_s ? pending_q : active_q;
        pending_d = xfer_s ? load_data : pending_q;

        // Transfer and commit are mutually exclusive: a transfer needs pending empty.
        if (commit_s) begin
            pend_valid_d = 1'b0;
        end else if (xfer_s) begin
            pend_valid_d = 1'b1;
        end else begin
            pend_valid_d = pend_valid_q;
        end

        load_ready_d  = ~pend_valid_d;
        nibble_d      = active_d[{sel_d, 2'b00} +: 4];
        frame_start_d = boundary_s;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= {PW{1'b0}};
            sel_q         <= 3'd0;
            active_q      <= 32'h0000_0000;
            pending_q     <= 32'h0000_0000;
            pend_valid_q  <= 1'b0;
            load_ready_q  <= 1'b1;
            nibble_q      <= 4'h0;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            sel_q         <= sel_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            pend_valid_q  <= pend_valid_d;
            load_ready_q  <= load_ready_d;
            nibble_q      <= nibble_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign load_ready  = load_ready_q;
    assign nibble      = nibble_q;
    assign sel         = sel_q;
    assign frame_start = frame_start_q;
    assign blank       = ~digit_en[sel_q];

endmodule
